// File: rtl/f2i_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | f2i_pkg : shared widths, FSM state and minifloat code layout          |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package f2i_pkg;

    localparam int EXP_W  = 3;
    localparam int MAN_W  = 4;
    localparam int INT_W  = MAN_W + 1 + (2**EXP_W) - 2;
    localparam int CODE_W = EXP_W + MAN_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } f2i_state_t;

    typedef struct packed {
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } mini_float_t;

endpackage
`default_nettype wire

// File: rtl/f2i_unpack.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | f2i_unpack : splits a minifloat code, restores the hidden bit and     |
// | yields the initial accumulator plus remaining shift count.            |
// | Option macro: F2I_BARREL_EN (full shift applied here, count = 0).     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module f2i_unpack
    import f2i_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [INT_W-1:0]  acc_init,
    output logic [EXP_W-1:0]  shift_cnt
);

    mini_float_t      w_fields;
    logic [INT_W-1:0] w_base;
    logic [EXP_W-1:0] w_shamt;

    assign w_fields = mini_float_t'(code);

    always_comb begin
        w_base  = '0;
        w_shamt = '0;
        if (w_fields.exp != '0) begin
            w_base  = {{(INT_W-MAN_W-1){1'b0}}, 1'b1, w_fields.man};
            w_shamt = w_fields.exp - EXP_W'(1);
        end else begin
            w_base  = {{(INT_W-MAN_W){1'b0}}, w_fields.man};
        end
    end

`ifdef F2I_BARREL_EN
    assign acc_init  = w_base << w_shamt;
    assign shift_cnt = '0;
`else
    assign acc_init  = w_base;
    assign shift_cnt = w_shamt;
`endif

endmodule
`default_nettype wire

// File: rtl/float2int_seq_decoder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | float2int_seq_decoder : minifloat -> unsigned integer, one shift per  |
// | cycle, valid/ready on both sides. Option macro: F2I_BARREL_EN.        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module float2int_seq_decoder
    import f2i_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INT_W-1:0]  out_int,
    output logic              busy
);

    f2i_state_t       r_state;
    logic [INT_W-1:0] r_acc;
    logic [EXP_W-1:0] r_cnt;
    logic [INT_W-1:0] w_acc_init;
    logic [EXP_W-1:0] w_shift_cnt;

    f2i_unpack u_unpack (
        .code      (in_code),
        .acc_init  (w_acc_init),
        .shift_cnt (w_shift_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_cnt     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_int   <= '0;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_acc    <= w_acc_init;
                        r_cnt    <= w_shift_cnt;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (w_shift_cnt == '0) begin
                            r_state   <= DONE;
                            out_valid <= 1'b1;
                            out_int   <= w_acc_init;
                        end else begin
                            r_state   <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    r_acc <= r_acc << 1;
                    r_cnt <= r_cnt - EXP_W'(1);
                    // the shift on this edge is the last one
                    if (r_cnt == EXP_W'(1)) begin
                        r_state   <= DONE;
                        out_valid <= 1'b1;
                        out_int   <= r_acc << 1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state   <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
